// File: rtl/multi_digit_bcd_counter_pkg.sv
// Shared constants for the cascaded BCD counter: decade width, digit limits
// and the saturate/wrap mode selectors.
package multi_digit_bcd_counter_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    localparam int SAT_WRAP = 0;
    localparam int SAT_HOLD = 1;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/multi_digit_bcd_counter_digit.sv
// One BCD decade: loads, or steps up/down by one with 9<->0 rollover, and
// flags when it sits at either limit so the parent can chain carries.
module bcd_digit
    import multi_digit_bcd_counter_pkg::*;
(
    input  logic             clock,
    input  logic             clear_n,
    input  logic             step,
    input  logic             up,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    output logic [BCD_W-1:0] digit,
    output logic             at_max,
    output logic             at_min
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= load_digit;
        end else if (step) begin
            if (up)
                digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
            else
                digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
        end
    end

    assign at_max = (digit == BCD_MAX);
    assign at_min = (digit == BCD_MIN);

endmodule

// File: rtl/multi_digit_bcd_counter.sv
// Cascaded up/down BCD counter with validated parallel load, terminal count,
// and wrap / load-error pulses. Optional saturation at the limits.
module multi_digit_bcd_counter
    import multi_digit_bcd_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SATURATE = SAT_WRAP
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step;
    logic              load_ok;
    logic              do_count;
    logic              at_limit;
    logic              blocked;

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(load_value[i*BCD_W +: BCD_W]))
                load_ok = 1'b0;
        end
    end

    // Any load request, even a rejected one, takes the edge away from counting.
    assign do_count = en && !load;
    assign at_limit = up ? (&at_max) : (&at_min);
    assign blocked  = (SATURATE == SAT_HOLD) && at_limit;
    assign tc       = en && at_limit;

    always_comb begin
        step    = '0;
        step[0] = do_count && !blocked;
        for (int k = 1; k < DIGITS; k++)
            step[k] = step[k-1] && (up ? at_max[k-1] : at_min[k-1]);
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clock      (clock),
            .clear_n    (clear_n),
            .step       (step[g]),
            .up         (up),
            .load       (load && load_ok),
            .load_digit (load_value[g*BCD_W +: BCD_W]),
            .digit      (count[g*BCD_W +: BCD_W]),
            .at_max     (at_max[g]),
            .at_min     (at_min[g])
        );
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= do_count && at_limit;
            load_err <= load && !load_ok;
        end
    end

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Directed bench: 2-digit wrap and saturate instances plus a 4-digit instance,
// all driven from one linear stimulus sequence.
module tb_multi_digit_bcd_counter;

    logic        clock;
    logic        clear_n;
    logic        en;
    logic        up;
    logic        load;
    logic [7:0]  lv2;
    logic [15:0] lv4;

    logic [7:0]  count0, count1;
    logic [15:0] count2;
    logic        tc0, tc1, tc2;
    logic        wrap0, wrap1, wrap2;
    logic        lerr0, lerr1, lerr2;

    int checks   = 0;
    int failures = 0;

    multi_digit_bcd_counter #(.DIGITS(2), .SATURATE(0)) dut_wrap (
        .clock(clock), .clear_n(clear_n), .en(en), .up(up), .load(load),
        .load_value(lv2), .count(count0), .tc(tc0), .wrap(wrap0), .load_err(lerr0));

    multi_digit_bcd_counter #(.DIGITS(2), .SATURATE(1)) dut_sat (
        .clock(clock), .clear_n(clear_n), .en(en), .up(up), .load(load),
        .load_value(lv2), .count(count1), .tc(tc1), .wrap(wrap1), .load_err(lerr1));

    multi_digit_bcd_counter #(.DIGITS(4), .SATURATE(0)) dut_d4 (
        .clock(clock), .clear_n(clear_n), .en(en), .up(up), .load(load),
        .load_value(lv4), .count(count2), .tc(tc2), .wrap(wrap2), .load_err(lerr2));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        clear_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; lv2 = 8'h00; lv4 = 16'h0000;
        #22;
        check("rst_count0", 16'(count0), 16'h00);
        check("rst_count1", 16'(count1), 16'h00);
        check("rst_count2", count2, 16'h0000);
        check("rst_wrap0", 16'(wrap0), 16'h0);
        check("rst_lerr0", 16'(lerr0), 16'h0);
        @(negedge clock);
        clear_n = 1'b1;

        // count up 01..11, no wrap
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            cycle();
            check("up_count0", 16'(count0), 16'(((i / 10) << 4) | (i % 10)));
            check("up_wrap0", 16'(wrap0), 16'h0);
        end
        check("up_count2", count2, 16'h0011);

        // load 98, step through 99 -> 00 -> 01
        en = 1'b0; load = 1'b1; lv2 = 8'h98;
        cycle();
        check("ld98_count0", 16'(count0), 16'h98);
        check("ld98_lerr0", 16'(lerr0), 16'h0);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1 check("tc_at98", 16'(tc0), 16'h0);
        cycle();
        check("c99_count0", 16'(count0), 16'h99);
        check("c99_tc0", 16'(tc0), 16'h1);
        check("c99_wrap0", 16'(wrap0), 16'h0);
        up = 1'b0;
        #1 check("c99_tc_down", 16'(tc0), 16'h0);
        up = 1'b1;
        #1 check("c99_tc_up", 16'(tc0), 16'h1);
        cycle();
        check("c00_count0", 16'(count0), 16'h00);
        check("c00_wrap0", 16'(wrap0), 16'h1);
        check("c00_tc0", 16'(tc0), 16'h0);
        check("sat99_count1", 16'(count1), 16'h99);
        check("sat99_wrap1", 16'(wrap1), 16'h1);
        check("sat99_tc1", 16'(tc1), 16'h1);
        cycle();
        check("c01_count0", 16'(count0), 16'h01);
        check("c01_wrap0", 16'(wrap0), 16'h0);
        check("sat99b_count1", 16'(count1), 16'h99);
        check("sat99b_wrap1", 16'(wrap1), 16'h1);

        // load 01, count down 00 -> 99 -> 98 (saturating copy stays at 00)
        en = 1'b0; load = 1'b1; lv2 = 8'h01;
        cycle();
        load = 1'b0; en = 1'b1; up = 1'b0;
        cycle();
        check("dn00_count0", 16'(count0), 16'h00);
        check("dn00_count1", 16'(count1), 16'h00);
        check("dn00_wrap0", 16'(wrap0), 16'h0);
        check("dn00_tc0", 16'(tc0), 16'h1);
        cycle();
        check("dn99_count0", 16'(count0), 16'h99);
        check("dn99_wrap0", 16'(wrap0), 16'h1);
        check("dnsat_count1", 16'(count1), 16'h00);
        check("dnsat_wrap1", 16'(wrap1), 16'h1);
        cycle();
        check("dn98_count0", 16'(count0), 16'h98);
        check("dn98_wrap0", 16'(wrap0), 16'h0);
        check("dnsat2_count1", 16'(count1), 16'h00);
        check("dnsat2_wrap1", 16'(wrap1), 16'h1);

        // rejected load of 3A while at 42
        en = 1'b0; load = 1'b1; lv2 = 8'h42;
        cycle();
        check("ld42_count0", 16'(count0), 16'h42);
        check("ld42_lerr0", 16'(lerr0), 16'h0);
        lv2 = 8'h3A; en = 1'b1; up = 1'b1;
        cycle();
        check("bad_count0", 16'(count0), 16'h42);
        check("bad_lerr0", 16'(lerr0), 16'h1);
        check("bad_wrap0", 16'(wrap0), 16'h0);
        load = 1'b0; en = 1'b0;
        cycle();
        check("hold_count0", 16'(count0), 16'h42);
        check("hold_lerr0", 16'(lerr0), 16'h0);
        check("hold_wrap0", 16'(wrap0), 16'h0);

        // async reset between edges while loading
        load = 1'b1; lv2 = 8'h57;
        cycle();
        check("ld57_count0", 16'(count0), 16'h57);
        lv2 = 8'h12; en = 1'b1;
        #2 clear_n = 1'b0;
        #1;
        check("arst_count0", 16'(count0), 16'h00);
        check("arst_count1", 16'(count1), 16'h00);
        check("arst_count2", count2, 16'h0000);
        load = 1'b0; en = 1'b0;
        #1 clear_n = 1'b1;
        cycle();
        check("post_rst_count0", 16'(count0), 16'h00);
        check("post_rst_lerr0", 16'(lerr0), 16'h0);

        // 4-digit carry ripple and wrap
        load = 1'b1; lv4 = 16'h0999; lv2 = 8'h00;
        cycle();
        check("d4_ld0999", count2, 16'h0999);
        load = 1'b0; en = 1'b1; up = 1'b1;
        cycle();
        check("d4_1000", count2, 16'h1000);
        check("d4_wrap_lo", 16'(wrap2), 16'h0);
        en = 1'b0; load = 1'b1; lv4 = 16'h1A00;
        cycle();
        check("d4_bad_count", count2, 16'h1000);
        check("d4_bad_lerr", 16'(lerr2), 16'h1);
        lv4 = 16'h9999;
        cycle();
        check("d4_ld9999", count2, 16'h9999);
        load = 1'b0; en = 1'b1;
        #1 check("d4_tc", 16'(tc2), 16'h1);
        cycle();
        check("d4_wrap_count", count2, 16'h0000);
        check("d4_wrap", 16'(wrap2), 16'h1);
        en = 1'b0; up = 1'b0;
        cycle();
        check("d4_down_tc_off", 16'(tc2), 16'h0);
        en = 1'b1;
        cycle();
        check("d4_borrow", count2, 16'h9999);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
